// File: rtl/bids22_pkg.sv
// Shared types and helpers for the bids22 host command sequencer.
package bids22_pkg;

    typedef enum logic [3:0] {
        OP_NOOP      = 4'd0,
        OP_UNLOCK    = 4'd1,
        OP_LOCK      = 4'd2,
        OP_LOADX     = 4'd3,
        OP_LOADY     = 4'd4,
        OP_LOADZ     = 4'd5,
        OP_MASK      = 4'd6,
        OP_TIMER     = 4'd7,
        OP_BIDCHARGE = 4'd8
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CHECK,
        S_RUN,
        S_WAIT_RES,
        S_FINISH,
        S_ABORT
    } state_e;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_CMD_ERR = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_X    = 2'd1;
    localparam logic [1:0] WIN_Y    = 2'd2;
    localparam logic [1:0] WIN_Z    = 2'd3;

    // Index 0 (Unlock) is skipped when the engine is known to be unlocked.
    localparam logic [2:0] IDX_UNLOCK = 3'd0;
    localparam logic [2:0] IDX_LOADX  = 3'd1;
    localparam logic [2:0] IDX_LOCK   = 3'd7;

    typedef struct packed {
        logic [31:0] key;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [2:0]  mask;
        logic [31:0] timer;
        logic [31:0] cost;
        logic [15:0] round_len;
    } cfg_t;

    function automatic op_e cmd_op(input logic [2:0] idx);
        op_e op;
        op = OP_NOOP;
        unique case (idx)
            3'd0: op = OP_UNLOCK;
            3'd1: op = OP_LOADX;
            3'd2: op = OP_LOADY;
            3'd3: op = OP_LOADZ;
            3'd4: op = OP_MASK;
            3'd5: op = OP_TIMER;
            3'd6: op = OP_BIDCHARGE;
            3'd7: op = OP_LOCK;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] cmd_data(input logic [2:0] idx,
                                             input cfg_t c);
        logic [31:0] d;
        d = c.key;
        case (idx)
            3'd1:    d = c.x;
            3'd2:    d = c.y;
            3'd3:    d = c.z;
            3'd4:    d = {29'b0, c.mask};
            3'd5:    d = c.timer;
            3'd6:    d = c.cost;
            default: d = c.key;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] winner_code(input logic x,
                                               input logic y,
                                               input logic z);
        logic [1:0] w;
        w = WIN_NONE;
        case ({z, y, x})
            3'b001:  w = WIN_X;
            3'b010:  w = WIN_Y;
            3'b100:  w = WIN_Z;
            default: w = WIN_NONE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bids22_dcount.sv
// Loadable 16-bit down-counter; saturates at zero and flags it.
module bids22_dcount (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] load_val,
    output logic        zero
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != 16'd0) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/bids22_host_seq.sv
// Host-side sequencer: programs a bids22 round, runs it, collects the result.
module bids22_host_seq
    import bids22_pkg::*;
#(
    parameter int unsigned RESULT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [31:0] cfg_key,
    input  logic [31:0] cfg_x_value,
    input  logic [31:0] cfg_y_value,
    input  logic [31:0] cfg_z_value,
    input  logic [2:0]  cfg_mask,
    input  logic [31:0] cfg_timer,
    input  logic [31:0] cfg_bid_cost,
    input  logic [15:0] round_len,
    output logic [3:0]  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    input  logic        ready,
    input  logic [1:0]  err,
    input  logic        roundOver,
    input  logic        X_win,
    input  logic        Y_win,
    input  logic        Z_win,
    input  logic [31:0] maxBid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [3:0]  fail_op,
    output logic [1:0]  res_winner,
    output logic [31:0] res_maxBid,
    output logic [1:0]  res_err
);

    // Counters run to zero, so they are loaded with (cycles - 1).
    localparam logic [15:0] TMO_LOAD = 16'(RESULT_TIMEOUT - 1);

    state_e      state;
    state_e      state_n;
    cfg_t        cfg;
    logic [2:0]  idx;
    logic        locked;
    logic        run_zero;
    logic        tmo_zero;
    logic [15:0] run_load;
    logic        run_ld;
    logic        run_en;
    logic        tmo_ld;
    logic        tmo_en;

    assign run_load = (cfg.round_len == 16'd0) ? 16'd0
                                               : cfg.round_len - 16'd1;
    assign run_ld   = (state == S_CHECK);
    assign run_en   = (state == S_RUN);
    assign tmo_ld   = (state == S_RUN);
    assign tmo_en   = (state == S_WAIT_RES);

    bids22_dcount u_run (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (run_ld),
        .en       (run_en),
        .load_val (run_load),
        .zero     (run_zero)
    );

    bids22_dcount u_tmo (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmo_ld),
        .en       (tmo_en),
        .load_val (TMO_LOAD),
        .zero     (tmo_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        C_op    = OP_NOOP;
        C_data  = '0;
        C_start = 1'b0;
        busy    = (state != S_IDLE);
        done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                C_op   = cmd_op(idx);
                C_data = cmd_data(idx, cfg);
                if (ready) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (err != 2'b00)       state_n = S_ABORT;
                else if (idx == IDX_LOCK) state_n = S_RUN;
                else                    state_n = S_ISSUE;
            end
            S_RUN: begin
                C_start = 1'b1;
                if (run_zero) state_n = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (roundOver || tmo_zero) state_n = S_FINISH;
            end
            S_ABORT: begin
                state_n = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg        <= '0;
            idx        <= '0;
            locked     <= 1'b0;
            status     <= ST_OK;
            fail_op    <= '0;
            res_winner <= WIN_NONE;
            res_maxBid <= '0;
            res_err    <= '0;
        end else begin
            if (state == S_IDLE && go) begin
                cfg.key       <= cfg_key;
                cfg.x         <= cfg_x_value;
                cfg.y         <= cfg_y_value;
                cfg.z         <= cfg_z_value;
                cfg.mask      <= cfg_mask;
                cfg.timer     <= cfg_timer;
                cfg.cost      <= cfg_bid_cost;
                cfg.round_len <= round_len;
                idx           <= locked ? IDX_UNLOCK : IDX_LOADX;
                status        <= ST_OK;
                fail_op       <= '0;
                res_winner    <= WIN_NONE;
                res_maxBid    <= '0;
                res_err       <= '0;
            end
            if (state == S_CHECK) begin
                if (err != 2'b00) begin
                    status  <= ST_CMD_ERR;
                    fail_op <= cmd_op(idx);
                end else begin
                    if (idx == IDX_LOCK)   locked <= 1'b1;
                    if (idx == IDX_UNLOCK) locked <= 1'b0;
                    if (idx != IDX_LOCK)   idx    <= idx + 3'd1;
                end
            end
            // A result arriving on the timeout cycle still counts.
            if (state == S_WAIT_RES) begin
                if (roundOver) begin
                    status     <= ST_OK;
                    res_winner <= winner_code(X_win, Y_win, Z_win);
                    res_maxBid <= maxBid;
                    res_err    <= err;
                end else if (tmo_zero) begin
                    status     <= ST_TIMEOUT;
                    res_winner <= WIN_NONE;
                    res_maxBid <= '0;
                    res_err    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bids22_host_seq.sv
// Directed self-checking bench for bids22_host_seq with a small engine model.
module tb_bids22_host_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic [31:0] cfg_key;
    logic [31:0] cfg_x_value;
    logic [31:0] cfg_y_value;
    logic [31:0] cfg_z_value;
    logic [2:0]  cfg_mask;
    logic [31:0] cfg_timer;
    logic [31:0] cfg_bid_cost;
    logic [15:0] round_len;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        ready;
    logic [1:0]  err;
    logic        roundOver;
    logic        X_win;
    logic        Y_win;
    logic        Z_win;
    logic [31:0] maxBid;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [3:0]  fail_op;
    logic [1:0]  res_winner;
    logic [31:0] res_maxBid;
    logic [1:0]  res_err;

    int checks = 0;
    int errors = 0;

    logic [3:0]  ops[$];
    logic [31:0] dats[$];
    int nstart;
    int first_start;
    int drop_cyc;
    int done_cyc;
    int nstall;
    int busy_low;

    always #5 clk = ~clk;

    bids22_host_seq #(.RESULT_TIMEOUT(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .go           (go),
        .cfg_key      (cfg_key),
        .cfg_x_value  (cfg_x_value),
        .cfg_y_value  (cfg_y_value),
        .cfg_z_value  (cfg_z_value),
        .cfg_mask     (cfg_mask),
        .cfg_timer    (cfg_timer),
        .cfg_bid_cost (cfg_bid_cost),
        .round_len    (round_len),
        .C_op         (C_op),
        .C_data       (C_data),
        .C_start      (C_start),
        .ready        (ready),
        .err          (err),
        .roundOver    (roundOver),
        .X_win        (X_win),
        .Y_win        (Y_win),
        .Z_win        (Z_win),
        .maxBid       (maxBid),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .fail_op      (fail_op),
        .res_winner   (res_winner),
        .res_maxBid   (res_maxBid),
        .res_err      (res_err)
    );

    task automatic set_cfg(input logic [31:0] k, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] z,
                           input logic [2:0] m, input logic [31:0] t,
                           input logic [31:0] c, input logic [15:0] l);
        cfg_key = k; cfg_x_value = x; cfg_y_value = y; cfg_z_value = z;
        cfg_mask = m; cfg_timer = t; cfg_bid_cost = c; round_len = l;
    endtask

    // Engine model: drives ready/err/roundOver and logs what the DUT does.
    task automatic run_round(input logic [3:0] err_op,
                             input logic [1:0] err_val,
                             input logic [3:0] stall_op,
                             input int stall_n, input int ro_delay,
                             input logic [1:0] ro_err, input int go_at);
        logic [3:0] acc_prev;
        int stall_left;
        int cyc;
        bit seen;
        ops.delete(); dats.delete();
        nstart = 0; first_start = 0; drop_cyc = 0;
        done_cyc = -1; nstall = 0; busy_low = 0;
        acc_prev = 4'd0; stall_left = stall_n; cyc = 0; seen = 0;
        ready = 1'b1; err = 2'b00; roundOver = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        cfg_key = ~cfg_key; cfg_x_value = ~cfg_x_value;
        cfg_y_value = ~cfg_y_value; cfg_z_value = ~cfg_z_value;
        cfg_mask = ~cfg_mask; cfg_timer = ~cfg_timer;
        cfg_bid_cost = ~cfg_bid_cost; round_len = ~round_len;
        while (!seen && cyc < 300) begin
            cyc++;
            if (!busy) busy_low++;
            if (C_start) begin
                nstart++;
                if (first_start == 0) first_start = cyc;
            end else if (nstart > 0 && drop_cyc == 0) begin
                drop_cyc = cyc;
            end
            if (stall_op != 4'd0 && C_op == stall_op) nstall++;
            if (done) begin
                seen = 1;
                done_cyc = cyc;
            end
            go = (cyc == go_at);
            err = (err_op != 4'd0 && acc_prev == err_op) ? err_val : 2'b00;
            ready = 1'b1;
            if (stall_op != 4'd0 && C_op == stall_op && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end
            if (C_op != 4'd0 && ready) begin
                ops.push_back(C_op);
                dats.push_back(C_data);
                acc_prev = C_op;
            end else begin
                acc_prev = 4'd0;
            end
            roundOver = (ro_delay >= 0 && drop_cyc != 0
                         && cyc - drop_cyc == ro_delay);
            if (roundOver) err = ro_err;
            if (!seen) begin
                @(posedge clk); #1;
            end
        end
        go = 1'b0; err = 2'b00; roundOver = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; go = 1'b0; ready = 1'b1; err = 2'b00;
        roundOver = 1'b0; X_win = 0; Y_win = 0; Z_win = 0; maxBid = '0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({C_op, C_data, C_start} !== 37'd0) begin
            errors++;
            $display("FAIL reset_cmd: got op=%0d data=%0h start=%0b want 0",
                     C_op, C_data, C_start);
        end
        checks++;
        if ({busy, done, status, fail_op} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctl: got busy=%0b done=%0b st=%0d fop=%0d want 0",
                     busy, done, status, fail_op);
        end
        checks++;
        if ({res_winner, res_maxBid, res_err} !== 36'd0) begin
            errors++;
            $display("FAIL reset_res: got w=%0d mb=%0d e=%0d want 0",
                     res_winner, res_maxBid, res_err);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_round;
        logic [3:0]  eo[$] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        logic [31:0] ed[$] = '{32'd100, 32'd200, 32'd300, 32'd7,
                               32'd1000, 32'd5, 32'hA5A50001};
        set_cfg(32'hA5A50001, 100, 200, 300, 3'd7, 1000, 5, 16'd4);
        X_win = 0; Y_win = 1; Z_win = 0; maxBid = 32'd50;
        run_round(4'd0, 2'd0, 4'd0, 0, 0, 2'd0, 0);
        checks++;
        if (ops.size() != 7) begin
            errors++;
            $display("FAIL r1_ncmd: got %0d want 7", ops.size());
        end
        for (int i = 0; i < ops.size() && i < 7; i++) begin
            checks++;
            if (ops[i] !== eo[i] || dats[i] !== ed[i]) begin
                errors++;
                $display("FAIL r1_cmd%0d: got op=%0d data=%0d want op=%0d data=%0d",
                         i, ops[i], dats[i], eo[i], ed[i]);
            end
        end
        checks++;
        if (nstart != 4 || first_start != 15) begin
            errors++;
            $display("FAIL r1_start: got len=%0d at=%0d want 4 at 15",
                     nstart, first_start);
        end
        checks++;
        if (done_cyc != 20 || busy_low != 0) begin
            errors++;
            $display("FAIL r1_done: got cyc=%0d busylow=%0d want 20 0",
                     done_cyc, busy_low);
        end
        checks++;
        if (status !== 2'd0 || res_winner !== 2'd2 || res_maxBid !== 32'd50
            || res_err !== 2'd0) begin
            errors++;
            $display("FAIL r1_res: got st=%0d w=%0d mb=%0d e=%0d want 0 2 50 0",
                     status, res_winner, res_maxBid, res_err);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL r1_idle: got busy=%0b done=%0b want 0 0", busy, done);
        end
    endtask

    task automatic test_unlock_round;
        logic [3:0]  eo[$] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        logic [31:0] ed[$] = '{32'h12345678, 32'd11, 32'd22, 32'd33,
                               32'd5, 32'd7, 32'd9, 32'h12345678};
        set_cfg(32'h12345678, 11, 22, 33, 3'b101, 7, 9, 16'd0);
        X_win = 1; Y_win = 0; Z_win = 0; maxBid = 32'd99;
        run_round(4'd0, 2'd0, 4'd0, 0, 0, 2'd0, 0);
        checks++;
        if (ops.size() != 8) begin
            errors++;
            $display("FAIL r2_ncmd: got %0d want 8", ops.size());
        end
        for (int i = 0; i < ops.size() && i < 8; i++) begin
            checks++;
            if (ops[i] !== eo[i] || dats[i] !== ed[i]) begin
                errors++;
                $display("FAIL r2_cmd%0d: got op=%0d data=%0h want op=%0d data=%0h",
                         i, ops[i], dats[i], eo[i], ed[i]);
            end
        end
        checks++;
        if (nstart != 1 || first_start != 17 || done_cyc != 19) begin
            errors++;
            $display("FAIL r2_timing: got len=%0d at=%0d done=%0d want 1 17 19",
                     nstart, first_start, done_cyc);
        end
        checks++;
        if (status !== 2'd0 || res_winner !== 2'd1 || res_maxBid !== 32'd99) begin
            errors++;
            $display("FAIL r2_res: got st=%0d w=%0d mb=%0d want 0 1 99",
                     status, res_winner, res_maxBid);
        end
    endtask

    task automatic test_cmd_error;
        set_cfg(32'h0000BEEF, 1, 2, 3, 3'd1, 4, 6, 16'd5);
        X_win = 1; Y_win = 0; Z_win = 0; maxBid = 32'd44;
        run_round(4'd4, 2'b10, 4'd0, 0, -1, 2'd0, 0);
        checks++;
        if (ops.size() != 3 || ops[0] !== 4'd1 || ops[2] !== 4'd4) begin
            errors++;
            $display("FAIL err_cmds: got n=%0d want Unlock,LoadX,LoadY only",
                     ops.size());
        end
        checks++;
        if (nstart != 0 || done_cyc != 8) begin
            errors++;
            $display("FAIL err_timing: got start=%0d done=%0d want 0 8",
                     nstart, done_cyc);
        end
        checks++;
        if (status !== 2'd1 || fail_op !== 4'd4 || res_winner !== 2'd0
            || res_maxBid !== 32'd0) begin
            errors++;
            $display("FAIL err_res: got st=%0d fop=%0d w=%0d mb=%0d want 1 4 0 0",
                     status, fail_op, res_winner, res_maxBid);
        end
    endtask

    task automatic test_ready_stall;
        logic [3:0] eo[$] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        set_cfg(32'h00000F0F, 10, 20, 30, 3'd2, 40, 50, 16'd2);
        X_win = 0; Y_win = 0; Z_win = 1; maxBid = 32'd77;
        run_round(4'd0, 2'd0, 4'd5, 3, 0, 2'd1, 0);
        checks++;
        if (ops.size() != 7) begin
            errors++;
            $display("FAIL st_ncmd: got %0d want 7", ops.size());
        end
        for (int i = 0; i < ops.size() && i < 7; i++) begin
            checks++;
            if (ops[i] !== eo[i]) begin
                errors++;
                $display("FAIL st_cmd%0d: got op=%0d want %0d", i, ops[i], eo[i]);
            end
        end
        checks++;
        if (nstall != 4 || dats[2] !== 32'd30) begin
            errors++;
            $display("FAIL st_hold: got cycles=%0d data=%0d want 4 30",
                     nstall, dats[2]);
        end
        checks++;
        if (nstart != 2 || first_start != 18 || done_cyc != 21) begin
            errors++;
            $display("FAIL st_timing: got len=%0d at=%0d done=%0d want 2 18 21",
                     nstart, first_start, done_cyc);
        end
        checks++;
        if (status !== 2'd0 || res_winner !== 2'd3 || res_maxBid !== 32'd77
            || res_err !== 2'd1 || fail_op !== 4'd0) begin
            errors++;
            $display("FAIL st_res: got st=%0d w=%0d mb=%0d e=%0d fop=%0d want 0 3 77 1 0",
                     status, res_winner, res_maxBid, res_err, fail_op);
        end
    endtask

    task automatic test_timeout;
        set_cfg(32'h0000CAFE, 5, 6, 7, 3'd7, 1, 2, 16'd3);
        X_win = 1; Y_win = 0; Z_win = 0; maxBid = 32'd55;
        run_round(4'd0, 2'd0, 4'd0, 0, -1, 2'd0, 0);
        checks++;
        if (ops.size() != 8 || ops[0] !== 4'd1) begin
            errors++;
            $display("FAIL to_cmds: got n=%0d want 8 starting with Unlock",
                     ops.size());
        end
        checks++;
        if (nstart != 3 || drop_cyc != 20 || done_cyc != 28) begin
            errors++;
            $display("FAIL to_timing: got len=%0d drop=%0d done=%0d want 3 20 28",
                     nstart, drop_cyc, done_cyc);
        end
        checks++;
        if (status !== 2'd2 || res_winner !== 2'd0 || res_maxBid !== 32'd0
            || res_err !== 2'd0) begin
            errors++;
            $display("FAIL to_res: got st=%0d w=%0d mb=%0d e=%0d want 2 0 0 0",
                     status, res_winner, res_maxBid, res_err);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        set_cfg(32'h00001111, 1, 2, 3, 3'd7, 1, 1, 16'd10);
        ready = 1'b1; err = 2'b00; roundOver = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        n = 0;
        while (!C_start && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (C_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_run: got start=%0b want 1", C_start);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (C_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || C_op !== 4'd0 || status !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid: got start=%0b busy=%0b done=%0b op=%0d st=%0d want 0",
                     C_start, busy, done, C_op, status);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ambiguous_and_go_busy;
        set_cfg(32'h00000077, 1, 1, 1, 3'd7, 3, 3, 16'd1);
        X_win = 1; Y_win = 1; Z_win = 0; maxBid = 32'd123;
        run_round(4'd0, 2'd0, 4'd0, 0, 1, 2'd0, 5);
        checks++;
        if (ops.size() != 7 || ops[0] !== 4'd3) begin
            errors++;
            $display("FAIL amb_cmds: got n=%0d first=%0d want 7 3",
                     ops.size(), ops[0]);
        end
        checks++;
        if (done_cyc != 18) begin
            errors++;
            $display("FAIL amb_done: got %0d want 18", done_cyc);
        end
        checks++;
        if (status !== 2'd0 || res_winner !== 2'd0 || res_maxBid !== 32'd123) begin
            errors++;
            $display("FAIL amb_res: got st=%0d w=%0d mb=%0d want 0 0 123",
                     status, res_winner, res_maxBid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || C_op !== 4'd0) begin
            errors++;
            $display("FAIL amb_noqueue: got busy=%0b op=%0d want 0 0", busy, C_op);
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_unlock_round();
        test_cmd_error();
        test_ready_stall();
        test_timeout();
        test_reset_mid_run();
        test_ambiguous_and_go_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
